// File: rtl/alu_arbiter_if.sv
// Requester and ALU pin bundle for the two-port ALU arbiter.
// The arbiter is attached through the slave modport; requesters and the ALU use the master modport.
interface alu_arbiter_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] data1_0;
    logic [DATA_W-1:0] data2_0;
    logic [DATA_W-1:0] data1_1;
    logic [DATA_W-1:0] data2_1;
    logic [SEL_W-1:0]  select_0;
    logic [SEL_W-1:0]  select_1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] result_0;
    logic [DATA_W-1:0] result_1;
    logic              zero_0;
    logic              zero_1;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_data2;
    logic [SEL_W-1:0]  alu_select;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              busy;

    modport master (
        output req0, req1, data1_0, data2_0, data1_1, data2_1, select_0, select_1,
        output alu_result, alu_zero,
        input  gnt0, gnt1, done0, done1, result_0, result_1, zero_0, zero_1,
        input  alu_data1, alu_data2, alu_select, busy
    );

    modport slave (
        input  req0, req1, data1_0, data2_0, data1_1, data2_1, select_0, select_1,
        input  alu_result, alu_zero,
        output gnt0, gnt1, done0, done1, result_0, result_1, zero_0, zero_1,
        output alu_data1, alu_data2, alu_select, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters: registers the winner's
// operands onto the ALU, waits SETTLE_CYCLES, then returns RESULT/ZERO with a DONE pulse.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              last, last_n;
    logic              win;

    logic              gnt0_q, gnt1_q, gnt0_n, gnt1_n;
    logic              done0_q, done1_q, done0_n, done1_n;
    logic [DATA_W-1:0] res0_q, res1_q, res0_n, res1_n;
    logic              zero0_q, zero1_q, zero0_n, zero1_n;
    logic [DATA_W-1:0] alu_d1_q, alu_d2_q, alu_d1_n, alu_d2_n;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_n;
    logic              busy_q, busy_n;

    // State and output registers; reset clears everything and arms port 0 for first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            res0_q    <= '0;
            res1_q    <= '0;
            zero0_q   <= 1'b0;
            zero1_q   <= 1'b0;
            alu_d1_q  <= '0;
            alu_d2_q  <= '0;
            alu_sel_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last      <= last_n;
            gnt0_q    <= gnt0_n;
            gnt1_q    <= gnt1_n;
            done0_q   <= done0_n;
            done1_q   <= done1_n;
            res0_q    <= res0_n;
            res1_q    <= res1_n;
            zero0_q   <= zero0_n;
            zero1_q   <= zero1_n;
            alu_d1_q  <= alu_d1_n;
            alu_d2_q  <= alu_d2_n;
            alu_sel_q <= alu_sel_n;
            busy_q    <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last;
        win       = 1'b0;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        done0_n   = 1'b0;
        done1_n   = 1'b0;
        res0_n    = res0_q;
        res1_n    = res1_q;
        zero0_n   = zero0_q;
        zero1_n   = zero1_q;
        alu_d1_n  = alu_d1_q;
        alu_d2_n  = alu_d2_q;
        alu_sel_n = alu_sel_q;

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Port 1 wins alone, or on contention when port 0 was served last
                    win       = bus.req1 && (!bus.req0 || !last);
                    alu_d1_n  = win ? bus.data1_1  : bus.data1_0;
                    alu_d2_n  = win ? bus.data2_1  : bus.data2_0;
                    alu_sel_n = win ? bus.select_1 : bus.select_0;
                    gnt0_n    = !win;
                    gnt1_n    = win;
                    last_n    = win;
                    cnt_n     = CNT_W'(SETTLE_CYCLES);
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    if (last) begin
                        res1_n  = bus.alu_result;
                        zero1_n = bus.alu_zero;
                        done1_n = 1'b1;
                    end else begin
                        res0_n  = bus.alu_result;
                        zero0_n = bus.alu_zero;
                        done0_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == WAIT);
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.result_0   = res0_q;
    assign bus.result_1   = res1_q;
    assign bus.zero_0     = zero0_q;
    assign bus.zero_1     = zero1_q;
    assign bus.alu_data1  = alu_d1_q;
    assign bus.alu_data2  = alu_d2_q;
    assign bus.alu_select = alu_sel_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: instance a uses SETTLE_CYCLES=1, instance b uses 3.
// Expected completions are queued when a request is driven and compared when DONE appears.
module tb_alu_arbiter;
    typedef struct {
        int         port;
        logic [7:0] res;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    alu_arbiter_if ifa();
    alu_arbiter_if ifb();

    alu_arbiter #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
    alu_arbiter #(.SETTLE_CYCLES(3)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

    // Behavioural ALU: FORWARD passes DATA2; ZERO flags DATA1+DATA2==0 for any opcode
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'b000:  return b;
            3'b001:  return 8'(a + b);
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        ifa.alu_result = alu_fn(ifa.alu_data1, ifa.alu_data2, ifa.alu_select);
        ifa.alu_zero   = (8'(ifa.alu_data1 + ifa.alu_data2) == 8'h00);
        ifb.alu_result = alu_fn(ifb.alu_data1, ifb.alu_data2, ifb.alu_select);
        ifb.alu_zero   = (8'(ifb.alu_data1 + ifb.alu_data2) == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input bit inst, input bit port, input logic v);
        if (inst) begin
            if (port) ifb.req1 = v; else ifb.req0 = v;
        end else begin
            if (port) ifa.req1 = v; else ifa.req0 = v;
        end
    endtask

    task automatic req_op(input bit inst, input bit port, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [2:0] sel, input logic [7:0] eres, input logic ezero);
        exp_t e;
        e.port = int'(port);
        e.res  = eres;
        e.zero = ezero;
        if (inst) qb.push_back(e); else qa.push_back(e);
        if (inst) begin
            if (port) begin ifb.data1_1 = d1; ifb.data2_1 = d2; ifb.select_1 = sel; end
            else      begin ifb.data1_0 = d1; ifb.data2_0 = d2; ifb.select_0 = sel; end
        end else begin
            if (port) begin ifa.data1_1 = d1; ifa.data2_1 = d2; ifa.select_1 = sel; end
            else      begin ifa.data1_0 = d1; ifa.data2_0 = d2; ifa.select_0 = sel; end
        end
        set_req(inst, port, 1'b1);
    endtask

    task automatic await_done(input bit inst, output int port);
        port = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst ? ifb.done0 : ifa.done0) begin port = 0; break; end
            if (inst ? ifb.done1 : ifa.done1) begin port = 1; break; end
        end
        if (port < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic sb_check(input bit inst, input int port);
        exp_t       e;
        logic [7:0] r;
        logic       z;
        if (port < 0) return;
        if ((inst ? qb.size() : qa.size()) == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        if (inst) e = qb.pop_front(); else e = qa.pop_front();
        if (inst) begin
            r = (port == 0) ? ifb.result_0 : ifb.result_1;
            z = (port == 0) ? ifb.zero_0   : ifb.zero_1;
        end else begin
            r = (port == 0) ? ifa.result_0 : ifa.result_1;
            z = (port == 0) ? ifa.zero_0   : ifa.zero_1;
        end
        check("done_port", 32'(port), 32'(e.port));
        check("result", 32'(r), 32'(e.res));
        check("zero", 32'(z), 32'(e.zero));
    endtask

    task automatic serve(input bit inst, input bit port);
        int p;
        cyc(1);
        check(port ? "gnt1" : "gnt0", 32'(inst ? (port ? ifb.gnt1 : ifb.gnt0) : (port ? ifa.gnt1 : ifa.gnt0)), 32'd1);
        set_req(inst, port, 1'b0);
        await_done(inst, p);
        sb_check(inst, p);
    endtask

    initial begin
        int p;
        int g[3];
        int d[3];
        int ng;
        int nd;
        int busy_cnt;

        {ifa.req0, ifa.req1, ifb.req0, ifb.req1} = '0;
        {ifa.data1_0, ifa.data2_0, ifa.data1_1, ifa.data2_1} = '0;
        {ifb.data1_0, ifb.data2_0, ifb.data1_1, ifb.data2_1} = '0;
        {ifa.select_0, ifa.select_1, ifb.select_0, ifb.select_1} = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        cyc(2);
        check("rst_gnt", 32'({ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1}), 32'd0);
        check("rst_res", 32'({ifa.result_0, ifa.result_1, ifa.zero_0, ifa.zero_1}), 32'd0);
        check("rst_alu", 32'({ifa.alu_data1, ifa.alu_data2, ifa.alu_select, ifa.busy}), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Single request, SETTLE_CYCLES=1
        req_op(1'b0, 1'b0, 8'h05, 8'h03, 3'b001, 8'h08, 1'b0);
        cyc(1);
        check("single_gnt0", 32'(ifa.gnt0), 32'd1);
        check("single_alu", 32'({ifa.alu_data1, ifa.alu_data2, ifa.alu_select}), 32'({8'h05, 8'h03, 3'b001}));
        check("single_busy", 32'(ifa.busy), 32'd1);
        ifa.req0 = 1'b0;
        cyc(1);
        check("single_done0", 32'(ifa.done0), 32'd1);
        check("single_gnt0_off", 32'(ifa.gnt0), 32'd0);
        sb_check(1'b0, 0);
        check("single_port1_idle", 32'({ifa.result_1, ifa.zero_1, ifa.done1, ifa.gnt1}), 32'd0);

        // Contention after reset: port 0 first, then port 1, then port 0 again
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0;
        req_op(1'b0, 1'b0, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0);
        req_op(1'b0, 1'b1, 8'h0F, 8'h30, 3'b011, 8'h3F, 1'b0);
        cyc(1);
        check("cont_gnt1_low", 32'(ifa.gnt1), 32'd0);
        check("cont_gnt0", 32'(ifa.gnt0), 32'd1);
        ifa.req0 = 1'b0;
        await_done(1'b0, p);
        sb_check(1'b0, p);
        serve(1'b0, 1'b1);
        check("cont_res0_kept", 32'(ifa.result_0), 32'h30);
        req_op(1'b0, 1'b0, 8'h11, 8'h22, 3'b011, 8'h33, 1'b0);
        req_op(1'b0, 1'b1, 8'h01, 8'h01, 3'b001, 8'h02, 1'b0);
        cyc(1);
        check("cont2_gnt0", 32'({ifa.gnt0, ifa.gnt1}), 32'b10);
        ifa.req0 = 1'b0;
        await_done(1'b0, p);
        sb_check(1'b0, p);
        serve(1'b0, 1'b1);

        // Zero flag comes straight from the ALU
        req_op(1'b0, 1'b1, 8'hFF, 8'h01, 3'b001, 8'h00, 1'b1);
        serve(1'b0, 1'b1);
        req_op(1'b0, 1'b1, 8'h01, 8'h00, 3'b000, 8'h00, 1'b0);
        serve(1'b0, 1'b1);

        // Unused opcode passes through to the ALU
        req_op(1'b0, 1'b0, 8'hA5, 8'h5A, 3'b101, 8'h00, 1'b0);
        cyc(1);
        check("inv_alu_sel", 32'(ifa.alu_select), 32'b101);
        ifa.req0 = 1'b0;
        await_done(1'b0, p);
        sb_check(1'b0, p);

        // SETTLE_CYCLES=3 with a held request
        for (int i = 0; i < 3; i++) req_op(1'b1, 1'b0, 8'h01, 8'h02, 3'b001, 8'h03, 1'b0);
        ng = 0;
        nd = 0;
        busy_cnt = 0;
        for (int t = 1; t <= 60 && nd < 3; t++) begin
            cyc(1);
            if (ifb.gnt0 && ng < 3) begin
                g[ng] = t;
                ng++;
                if (ng == 3) ifb.req0 = 1'b0;
            end
            if (ifb.busy) busy_cnt++;
            if (ifb.done0) begin
                d[nd] = t;
                nd++;
                sb_check(1'b1, 0);
            end
        end
        check("held_ngrant", 32'(ng), 32'd3);
        check("held_ndone", 32'(nd), 32'd3);
        check("held_spacing01", 32'(g[1] - g[0]), 32'd4);
        check("held_spacing12", 32'(g[2] - g[1]), 32'd4);
        check("held_latency", 32'(d[0] - g[0]), 32'd3);
        check("held_busy", 32'(busy_cnt), 32'd9);

        // Reset mid-WAIT aborts without DONE
        ifb.data1_0 = 8'h05;
        ifb.data2_0 = 8'h03;
        ifb.select_0 = 3'b001;
        ifb.req0 = 1'b1;
        cyc(1);
        check("abort_gnt0", 32'(ifb.gnt0), 32'd1);
        rst_b = 1'b1;
        cyc(1);
        check("abort_flags", 32'({ifb.gnt0, ifb.gnt1, ifb.done0, ifb.done1, ifb.busy}), 32'd0);
        check("abort_res", 32'({ifb.result_0, ifb.result_1, ifb.zero_0, ifb.zero_1}), 32'd0);
        check("abort_alu", 32'({ifb.alu_data1, ifb.alu_data2, ifb.alu_select}), 32'd0);
        rst_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            check("abort_no_done", 32'({ifb.done0, ifb.done1}), 32'd0);
            if (ifb.gnt0) break;
        end
        check("abort_regrant", 32'(ifb.gnt0), 32'd1);
        ifb.req0 = 1'b0;
        req_op(1'b1, 1'b0, 8'h05, 8'h03, 3'b001, 8'h08, 1'b0);
        ifb.req0 = 1'b0;
        await_done(1'b1, p);
        sb_check(1'b1, p);

        check("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 8-bit ALU between two requesters, e.g. the main datapath and an auxiliary address/step unit. It accepts one operation at a time and registers the operands onto the ALU inputs. It waits a fixed settle interval, captures RESULT and ZERO, and returns them to the winning port with a one-cycle DONE pulse. It sits between the requesters and the ALU's DATA1/DATA2/SELECT/RESULT/ZERO pins.

## Interface
- SETTLE_CYCLES, 1: number of clock cycles the ALU inputs are held before RESULT/ZERO are captured. Legal range is 1..15.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- REQ0, REQ1  in  1 each  operation request from port 0 / port 1.
- DATA1_0, DATA2_0, DATA1_1, DATA2_1  in  8 each  operands per port.
- SELECT_0, SELECT_1  in  3 each  ALU opcode per port: 000 FORWARD, 001 ADD, 010 AND, 011 OR.
- GNT0, GNT1  out  1 each  one-cycle pulse: request accepted and operands latched.
- DONE0, DONE1  out  1 each  one-cycle pulse: RESULT_x/ZERO_x updated.
- RESULT_0, RESULT_1  out  8 each  captured ALU result per port.
- ZERO_0, ZERO_1  out  1 each  captured ALU ZERO per port.
- ALU_DATA1, ALU_DATA2  out  8 each  registered operands driven to the ALU.
- ALU_SELECT  out  3  registered opcode driven to the ALU.
- ALU_RESULT  in  8  ALU RESULT.
- ALU_ZERO  in  1  ALU ZERO.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- The FSM has two states, IDLE and WAIT. It also holds a 4-bit settle counter CNT and a 1-bit round-robin pointer LAST, which records the last port granted.
- IDLE:
  - REQx is sampled only in IDLE. When no REQ is high, the block stays in IDLE.
  - When exactly one REQ is high, that port wins.
  - When both REQs are high, the port != LAST wins.
  - On acceptance: latch the winner's DATA1/DATA2/SELECT into ALU_DATA1/ALU_DATA2/ALU_SELECT, set GNTw=1, set LAST=w, set CNT=SETTLE_CYCLES, and go to WAIT.
- WAIT:
  - CNT decrements on each edge.
  - On the edge where CNT==1: capture ALU_RESULT→RESULT_w and ALU_ZERO→ZERO_w, pulse DONEw, and return to IDLE.
- GNTx and DONEx are registered pulses that are high for exactly one cycle. They are never high for both ports in the same cycle.
- Requester rule: hold REQ and operands stable until GNT is seen, then deassert REQ in the same cycle. A REQ still high in the IDLE cycle after DONE counts as a new request.
- ALU_DATA1/ALU_DATA2/ALU_SELECT hold their values after DONE until the next acceptance.
- RESULT_x/ZERO_x hold their values until the next completion on that same port. A completion on the other port never touches them.
- SELECT is passed through unfiltered. Opcodes 1xx reach the ALU, which returns 0, and that 0 is captured.
- ZERO is captured exactly as the ALU drives it; no re-derivation from RESULT. The ALU's ZERO reflects DATA1+DATA2==0 regardless of SELECT.
- A request is never dropped. A losing port keeps REQ high and is served in the next IDLE cycle.

## Timing
- Reset values: all outputs are 0, i.e. GNT*, DONE*, RESULT_*, ZERO_*, ALU_*, and BUSY. Also state=IDLE, CNT=0, and LAST=1, so port 0 wins the first contention.
- Request-to-result latency: for acceptance at edge E, GNT is high in cycle E..E+1. DONE and the new RESULT are visible after edge E+SETTLE_CYCLES.
- BUSY is high from edge E to edge E+SETTLE_CYCLES.
- The earliest next acceptance is at edge E+SETTLE_CYCLES+1. Sustained throughput is one operation per SETTLE_CYCLES+1 cycles.
- The ALU inputs are stable for SETTLE_CYCLES full cycles before capture.
- RESET takes priority over everything on any edge. RESET mid-WAIT aborts the operation: no DONE is issued, and all outputs, including RESULT_*, return to 0.
- Any REQ sampled with RESET high is ignored.
- REQ changes during WAIT have no effect.

## Test plan
- Single request, SETTLE_CYCLES=1: REQ0=1, DATA1_0=8'h05, DATA2_0=8'h03, SELECT_0=001 → GNT0 for 1 cycle, ALU_* = 05/03/001, then DONE0 next cycle with RESULT_0=8'h08 and ZERO_0=0. Port 1 outputs stay at 0.
- Contention after reset: both REQ high, port 0 AND 8'hF0&8'h3C, port 1 OR 8'h0F|8'h30 → port 0 is served first with RESULT_0=8'h30, then port 1 on the next IDLE with RESULT_1=8'h3F. A second contention grants port 0 again.
- Zero flag: port 1 ADD 8'hFF+8'h01 → RESULT_1=8'h00, ZERO_1=1. Then port 1 FORWARD with DATA2=8'h00 and DATA1=8'h01 → RESULT_1=8'h00, ZERO_1=0, because ZERO comes from the ALU unchanged.
- SETTLE_CYCLES=3 with a held request: REQ0 held high across operations → GNT0 spacing is exactly 4 cycles, DONE0 comes 3 edges after acceptance, and BUSY is high for 3 cycles per operation.
- Reset mid-WAIT, SETTLE_CYCLES=3: RESET asserted one cycle after GNT0 → no DONE0, all outputs 0, state IDLE. With REQ0 still high after RESET falls, a grant occurs on the next edge.
- Invalid opcode: SELECT_0=101 with arbitrary operands → ALU_SELECT=101 and RESULT_0=8'h00 after DONE0.
